// File: rtl/apb_arbiter.sv
// apb_arbiter: two-requester round-robin APB master.
// Define APB_ARB_TIMEOUT_EN to abort PREADY waits after TMO_CYCLES with ERR=1.
module apb_arbiter #(
   parameter int AWIDTH     = 8,
   parameter int DWIDTH     = 8,
   parameter int TMO_CYCLES = 15
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic [1:0]        REQ,
   input  logic [1:0]        WR,
   input  logic [AWIDTH-1:0] ADDR0,
   input  logic [AWIDTH-1:0] ADDR1,
   input  logic [DWIDTH-1:0] WDATA0,
   input  logic [DWIDTH-1:0] WDATA1,
   output logic [1:0]        DONE,
   output logic [DWIDTH-1:0] RDATA,
   output logic              ERR,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [AWIDTH-1:0] PADDR,
   output logic [DWIDTH-1:0] PWDATA,
   input  logic [DWIDTH-1:0] PRDATA,
   input  logic              PREADY
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   state_t state, state_nx;
   logic pri, gnt, win, start, fin, tmo_hit;
   logic [1:0] elig;
   if (TMO_CYCLES < 1 || TMO_CYCLES > 255) begin : g_bad_tmo
      $error("apb_arbiter: TMO_CYCLES must be 1..255");
   end
   // a requester being acknowledged this cycle still holds REQ and must not be re-granted
   assign elig    = REQ & ~DONE;
   assign win     = elig[pri] ? pri : ~pri;
   assign PSEL    = state != IDLE;
   assign PENABLE = state == ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
   logic [7:0] tmo;
   assign tmo_hit = state == ACCESS && !PREADY && tmo == 8'(TMO_CYCLES - 1);
   always_ff @(posedge PCLK)
      if (PRESET) begin
         tmo <= '0;
         ERR <= 1'b0;
      end else begin
         tmo <= start ? 8'd0 : (state == ACCESS && !PREADY) ? tmo + 8'd1 : tmo;
         ERR <= tmo_hit;
      end
`else
   assign tmo_hit = 1'b0;
   assign ERR     = 1'b0;
`endif
   always_comb begin
      start    = state == IDLE && |elig;
      fin      = state == ACCESS && (PREADY || tmo_hit);
      state_nx = start ? SETUP : state == SETUP ? ACCESS : fin ? IDLE : state;
   end
   always_ff @(posedge PCLK)
      if (PRESET) begin
         state  <= IDLE;
         pri    <= 1'b0;
         gnt    <= 1'b0;
         PWRITE <= 1'b0;
         PADDR  <= '0;
         PWDATA <= '0;
         DONE   <= '0;
         RDATA  <= '0;
      end else begin
         state <= state_nx;
         DONE  <= fin ? (gnt ? 2'b10 : 2'b01) : 2'b00;
         if (start) begin
            gnt    <= win;
            pri    <= ~win;
            PWRITE <= WR[win];
            PADDR  <= win ? ADDR1 : ADDR0;
            PWDATA <= win ? WDATA1 : WDATA0;
         end
         if (fin && PREADY && !PWRITE) RDATA <= PRDATA;
      end
endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: scoreboard bench for apb_arbiter with a memory-backed APB slave and a transaction-level arbitration model.
module tb_apb_arbiter;
   logic PCLK = 1'b0;
   logic PRESET;
   logic [1:0] REQ, WR, DONE;
   logic [7:0] ADDR0, ADDR1, WDATA0, WDATA1, RDATA, PADDR, PWDATA, PRDATA;
   logic ERR, PSEL, PENABLE, PWRITE, PREADY;

   apb_arbiter #(.AWIDTH(8), .DWIDTH(8), .TMO_CYCLES(15)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .REQ(REQ), .WR(WR),
      .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
      .DONE(DONE), .RDATA(RDATA), .ERR(ERR),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      bit id;
      bit wr;
      logic [7:0] addr;
      logic [7:0] wd;
      logic [7:0] rd;
      bit err;
   } exp_t;

   exp_t sb[$];
   int wq[$];
   int passed = 0, total = 0;
   logic [7:0] smem [256];
   logic [7:0] mmem [256];
   logic [7:0] last_rd = 8'h00;
   bit pri_m = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Reference model: grants are served in the order the bench predicts, memory semantics decide read data
   function automatic void push_exp(input bit id, input bit w, input logic [7:0] a, input logic [7:0] d,
                                    input int lows, input bit err);
      exp_t e;
      e.id = id; e.wr = w; e.addr = a; e.wd = d; e.err = err;
      if (!err && w) mmem[a] = d;
      if (!err && !w) last_rd = mmem[a];
      e.rd = last_rd;
      sb.push_back(e);
      wq.push_back(err ? 1000 : lows);
      pri_m = ~id;
   endfunction

   // APB slave: waits the queued number of ACCESS cycles, then completes against its memory
   int sw = 0;
   always begin
      @(posedge PCLK); #2;
      if (PSEL && !PENABLE) sw = wq.size() != 0 ? wq.pop_front() : 0;
      if (PSEL && PENABLE) begin
         PREADY = sw == 0;
         PRDATA = (sw == 0 && !PWRITE) ? smem[PADDR] : 8'($urandom);
         if (sw == 0 && PWRITE) smem[PADDR] = PWDATA;
         if (sw != 0) sw--;
      end else begin
         PREADY = 1'($urandom);
         PRDATA = 8'($urandom);
      end
   end

   // Monitor: APB protocol rules plus scoreboard comparison on every DONE pulse
   logic p_sel = 1'b0, p_en = 1'b0, p_wr = 1'b0, s_wr = 1'b0, viol;
   logic [7:0] p_addr = '0, p_wd = '0, s_addr = '0, s_wd = '0;
   exp_t me;
   always begin
      @(posedge PCLK); #1;
      if (!PRESET) begin
         viol = (PENABLE && !PSEL)
             || (p_sel && !p_en && !(PSEL && PENABLE))
             || (p_sel && p_en && !PREADY && !(PSEL && PENABLE) && !(DONE != 2'b00 && ERR))
             || (p_sel && PSEL && {PADDR, PWRITE, PWDATA} != {p_addr, p_wr, p_wd})
             || (p_sel && p_en && PREADY && PSEL)
             || (!p_sel && PSEL && PENABLE);
         if (PSEL || p_sel) chk("apb_proto", viol, 0);
         if (PSEL && !PENABLE) begin
            s_addr = PADDR; s_wr = PWRITE; s_wd = PWDATA;
         end
         if (DONE != 2'b00) begin
            if (sb.size() == 0) chk("done_unexpected", DONE, 0);
            else begin
               me = sb.pop_front();
               chk("done", DONE, me.id ? 2'b10 : 2'b01);
               chk("err", ERR, me.err);
               chk("rdata", RDATA, me.rd);
               chk("paddr", s_addr, me.addr);
               chk("pwrite", s_wr, me.wr);
               if (me.wr) chk("pwdata", s_wd, me.wd);
            end
         end
      end
      p_sel = PSEL; p_en = PENABLE; p_addr = PADDR; p_wr = PWRITE; p_wd = PWDATA;
   end

   task automatic scramble(input bit i);
      WR[i] = 1'($urandom);
      if (i) begin ADDR1 = 8'($urandom); WDATA1 = 8'($urandom); end
      else begin ADDR0 = 8'($urandom); WDATA0 = 8'($urandom); end
   endtask

   task automatic single(input bit id, input bit w, input logic [7:0] a, input logic [7:0] d,
                         input int lows, input bit err);
      logic [1:0] oh;
      oh = id ? 2'b10 : 2'b01;
      push_exp(id, w, a, d, lows, err);
      @(negedge PCLK);
      WR[id] = w;
      if (id) begin ADDR1 = a; WDATA1 = d; end else begin ADDR0 = a; WDATA0 = d; end
      REQ = oh;
      @(posedge PCLK); #1;
      chk("setup_sel_en", {PSEL, PENABLE}, 2'b10);
      chk("setup_paddr", PADDR, a);
      chk("setup_pwrite", PWRITE, w);
      chk("setup_pwdata", PWDATA, d);
      @(negedge PCLK); scramble(id);
      repeat (err ? lows : lows + 1) begin
         @(posedge PCLK); #1;
         chk("access_sel_en_done", {PSEL, PENABLE, DONE}, 4'b1100);
      end
      @(posedge PCLK); #1;
      chk("complete", {PSEL, PENABLE, DONE, ERR}, {2'b00, oh, err});
      @(negedge PCLK); REQ = 2'b00;
   endtask

   task automatic round(input logic [1:0] m);
      bit ord[2];
      bit w[2];
      logic [7:0] a[2], d[2];
      logic [1:0] pend, got;
      bit setup;
      int no, ns, n;
      for (int i = 0; i < 2; i++) begin
         w[i] = 1'($urandom); a[i] = 8'($urandom_range(0, 7)); d[i] = 8'($urandom);
      end
      ord[0] = (m == 2'b11) ? pri_m : m[1];
      ord[1] = ~ord[0];
      no = (m == 2'b11) ? 2 : 1;
      for (int k = 0; k < no; k++) push_exp(ord[k], w[ord[k]], a[ord[k]], d[ord[k]], $urandom_range(0, 4), 1'b0);
      @(negedge PCLK);
      WR = {w[1], w[0]}; ADDR0 = a[0]; ADDR1 = a[1]; WDATA0 = d[0]; WDATA1 = d[1]; REQ = m;
      pend = m; ns = 0; n = 0;
      while (pend != 2'b00 && n < 60) begin
         @(posedge PCLK); #1;
         got = DONE; setup = PSEL && !PENABLE;
         @(negedge PCLK);
         if (setup && ns < no) begin scramble(ord[ns]); ns++; end
         REQ = REQ & ~got; pend = pend & ~got; n++;
      end
      chk("round_done", pend, 0);
   endtask

   task automatic skip_test();
      int n;
      push_exp(1'b0, 1'b0, 8'h06, 8'h00, 3, 1'b0);
      @(negedge PCLK); WR[0] = 1'b0; ADDR0 = 8'h06; REQ = 2'b01;
      @(posedge PCLK); #1; chk("skip_setup", {PSEL, PENABLE}, 2'b10);
      @(negedge PCLK); REQ = 2'b10;
      @(negedge PCLK); REQ = 2'b00;
      n = 0;
      do begin @(posedge PCLK); #1; n++; end while (DONE == 2'b00 && n < 20);
      chk("skip_done", DONE, 2'b01);
      repeat (4) begin @(posedge PCLK); #1; chk("skip_idle", PSEL, 0); end
   endtask

   task automatic reset_test();
      single(1'b0, 1'b1, 8'h03, 8'h99, 0, 1'b0);
      wq.push_back(1000);
      @(negedge PCLK); WR[1] = 1'b0; ADDR1 = 8'h04; REQ = 2'b10;
      repeat (4) @(negedge PCLK);
      PRESET = 1'b1; REQ = 2'b00;
      @(posedge PCLK); #1;
      chk("rst_mid_sel_en_done", {PSEL, PENABLE, DONE}, 0);
      chk("rst_mid_rdata", RDATA, 0);
      @(negedge PCLK); PRESET = 1'b0;
      pri_m = 1'b0; last_rd = 8'h00;
      round(2'b11);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      PRESET = 1'b1; REQ = 2'b00; WR = 2'b00;
      ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
      for (int i = 0; i < 256; i++) begin smem[i] = 8'($urandom); mmem[i] = smem[i]; end
      smem[8'h34] = 8'hC3; mmem[8'h34] = 8'hC3;
      repeat (3) @(posedge PCLK);
      #1;
      chk("rst_ctrl", {PSEL, PENABLE, PWRITE, DONE, ERR}, 0);
      chk("rst_paddr", PADDR, 0);
      chk("rst_pwdata", PWDATA, 0);
      chk("rst_rdata", RDATA, 0);
      @(negedge PCLK); PRESET = 1'b0;
      single(1'b0, 1'b1, 8'h12, 8'h5A, 0, 1'b0);
      single(1'b1, 1'b0, 8'h34, 8'h00, 3, 1'b0);
      chk("read_c3", RDATA, 8'hC3);
`ifdef APB_ARB_TIMEOUT_EN
      single(1'b0, 1'b1, 8'h05, 8'h77, 15, 1'b1);
`endif
      skip_test();
      repeat (4) round(2'b11);
      reset_test();
      repeat (30) begin
         round(2'($urandom_range(1, 3)));
         repeat ($urandom_range(0, 2)) @(negedge PCLK);
      end
      repeat (5) @(negedge PCLK);
      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
